pipelined_zero_counter: RTL and testbench

Two-stage pipelined leading/trailing zero counter for integer and floating-point normalisation datapaths. It generalises the combinational nibble-based leading-zero counter to any power-of-two width from 8 to 64 bits. It adds a per-transaction count-direction mode, a pass-through tag, and a valid/ready handshake on both sides, so it can sit directly between a producer stage and a normaliser shifter under back-pressure.

---
 rtl/pipelined_zero_counter_pkg.sv | 23 ++
 rtl/nibble_local_count.sv | 22 ++
 rtl/priority_nibble_encoder.sv | 24 ++
 rtl/pipelined_zero_counter.sv | 116 +++++++++++
 tb/tb_pipelined_zero_counter.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipelined_zero_counter_pkg.sv
// Shared types and width helpers for the pipelined leading/trailing zero counter.
// Widths are derived from the operand width so every file agrees on field sizes.
package pipelined_zero_counter_pkg;

    typedef enum logic {
        LEADING  = 1'b0,
        TRAILING = 1'b1
    } count_mode_t;

    function automatic int NIBBLES(input int width);
        return width / 4;
    endfunction

    function automatic int CNT_WIDTH(input int width);
        return $clog2(width) + 1;
    endfunction

    // Bit-reverses a nibble so trailing-zero counting can reuse the leading-zero cell.
    function automatic logic [3:0] nibble_reverse(input logic [3:0] nib);
        return {nib[0], nib[1], nib[2], nib[3]};
    endfunction

endpackage

// File: rtl/nibble_local_count.sv
// Leading-zero count of one nibble, scanning from bit 3 down.
// The count saturates at 3 when the nibble is all-zero; all_zero_o flags that case.
module nibble_local_count (
    input  logic [3:0] nibble_i,
    output logic [1:0] count_o,
    output logic       all_zero_o
);

    always_comb begin
        count_o = 2'd3;
        if (nibble_i[3]) begin
            count_o = 2'd0;
        end else if (nibble_i[2]) begin
            count_o = 2'd1;
        end else if (nibble_i[1]) begin
            count_o = 2'd2;
        end
    end

    assign all_zero_o = (nibble_i == 4'h0);

endmodule

// File: rtl/priority_nibble_encoder.sv
// Finds the lowest-indexed nibble that is not all-zero in a scan-ordered vector.
// Index 0 is the first nibble scanned, so the lowest index wins.
module priority_nibble_encoder #(
    parameter int N = 8
) (
    input  logic [N-1:0]         zero_i,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 all_zero_o
);

    localparam int IW = $clog2(N);

    always_comb begin
        idx_o = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (!zero_i[k]) begin
                idx_o = k[IW-1:0];
            end
        end
    end

    assign all_zero_o = &zero_i;

endmodule

// File: rtl/pipelined_zero_counter.sv
// Two-stage leading/trailing zero counter with valid/ready on both sides.
// S1 holds per-nibble counts in scan order; S2 holds the encoded final count.
module pipelined_zero_counter
    import pipelined_zero_counter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_n_i,
    input  logic                             valid_i,
    output logic                             ready_o,
    input  logic [DATA_WIDTH-1:0]            operand_i,
    input  logic                             mode_i,
    input  logic [TAG_WIDTH-1:0]             tag_i,
    output logic                             valid_o,
    input  logic                             ready_i,
    output logic [CNT_WIDTH(DATA_WIDTH)-1:0] count_o,
    output logic                             is_zero_o,
    output logic [TAG_WIDTH-1:0]             tag_o
);

    localparam int NIB = NIBBLES(DATA_WIDTH);
    localparam int CW  = CNT_WIDTH(DATA_WIDTH);
    localparam int IW  = CW - 3;

    logic [NIB-1:0][1:0] loc_cnt;
    logic [NIB-1:0]      loc_zero;

    logic [NIB-1:0][1:0] s1_cnt_q;
    logic [NIB-1:0]      s1_zero_q;
    logic [TAG_WIDTH-1:0] s1_tag_q;
    logic                s1_valid_q, s1_valid_d;
    logic                s2_valid_q, s2_valid_d;
    logic [CW-1:0]       count_q, count_d;
    logic                is_zero_q;
    logic [TAG_WIDTH-1:0] tag_q;

    logic          in_fire, s2_load, out_fire;
    logic [IW-1:0] enc_idx;
    logic          enc_all_zero;

    // Scan index 0 is the MSB nibble in leading mode and the LSB nibble in trailing mode.
    for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
        logic [3:0] scan_nib;
        assign scan_nib = (count_mode_t'(mode_i) == TRAILING)
                        ? nibble_reverse(operand_i[4*gi +: 4])
                        : operand_i[4*(NIB-1-gi) +: 4];
        nibble_local_count u_nlc (
            .nibble_i   (scan_nib),
            .count_o    (loc_cnt[gi]),
            .all_zero_o (loc_zero[gi])
        );
    end

    priority_nibble_encoder #(.N(NIB)) u_enc (
        .zero_i     (s1_zero_q),
        .idx_o      (enc_idx),
        .all_zero_o (enc_all_zero)
    );

    assign ready_o  = !s1_valid_q || !s2_valid_q || ready_i;
    assign in_fire  = valid_i && ready_o;
    assign out_fire = s2_valid_q && ready_i;
    assign s2_load  = s1_valid_q && (!s2_valid_q || ready_i);

    always_comb begin
        s1_valid_d = s1_valid_q;
        if (in_fire) begin
            s1_valid_d = 1'b1;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end
        s2_valid_d = s2_valid_q;
        if (s2_load) begin
            s2_valid_d = 1'b1;
        end else if (out_fire) begin
            s2_valid_d = 1'b0;
        end
        count_d = enc_all_zero ? {1'b1, {(CW-1){1'b0}}}
                               : {1'b0, enc_idx, s1_cnt_q[enc_idx]};
    end

    // Mode is fully consumed by the S1 scan ordering, so only counts, flags and tag are staged.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_cnt_q   <= '0;
            s1_zero_q  <= '0;
            s1_tag_q   <= '0;
            count_q    <= '0;
            is_zero_q  <= 1'b0;
            tag_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            if (in_fire) begin
                s1_cnt_q  <= loc_cnt;
                s1_zero_q <= loc_zero;
                s1_tag_q  <= tag_i;
            end
            if (s2_load) begin
                count_q   <= count_d;
                is_zero_q <= enc_all_zero;
                tag_q     <= s1_tag_q;
            end
        end
    end

    assign valid_o   = s2_valid_q;
    assign count_o   = count_q;
    assign is_zero_o = is_zero_q;
    assign tag_o     = tag_q;

endmodule

// File: tb/tb_pipelined_zero_counter.sv
// Scoreboard bench: the driver queues expected results on each input transfer,
// a negedge monitor compares every presented result against the queue head.
module tb_pipelined_zero_counter;

    localparam int DW = 32;
    localparam int TW = 4;
    localparam int CW = 6;

    typedef struct {
        logic [CW-1:0] cnt;
        logic          z;
        logic [TW-1:0] tag;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid_i, ready_o, mode_i, valid_o, ready_i, is_zero_o;
    logic [DW-1:0] operand_i;
    logic [TW-1:0] tag_i, tag_o;
    logic [CW-1:0] count_o;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    bit   rnd_stop;

    logic        aux_valid, aux_mode;
    logic [3:0]  aux_tag;
    logic [63:0] aux_op;
    logic        aux_ready;
    int          aux_rx[3];

    always #5 clk = ~clk;

    pipelined_zero_counter #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .operand_i (operand_i),
        .mode_i    (mode_i),
        .tag_i     (tag_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .count_o   (count_o),
        .is_zero_o (is_zero_o),
        .tag_o     (tag_o)
    );

    // Extra instances at 8, 16 and 64 bits check the all-zero width boundary.
    for (genvar gi = 0; gi < 3; gi++) begin : g_aux
        localparam int W   = (gi == 2) ? 64 : (8 << gi);
        localparam int ACW = $clog2(W) + 1;
        logic           vo, ro, z;
        logic [ACW-1:0] c;
        logic [3:0]     t;

        pipelined_zero_counter #(.DATA_WIDTH(W), .TAG_WIDTH(4)) u_aux (
            .clk_i     (clk),
            .rst_n_i   (rst_n),
            .valid_i   (aux_valid),
            .ready_o   (ro),
            .operand_i (aux_op[W-1:0]),
            .mode_i    (aux_mode),
            .tag_i     (aux_tag),
            .valid_o   (vo),
            .ready_i   (aux_ready),
            .count_o   (c),
            .is_zero_o (z),
            .tag_o     (t)
        );

        always @(negedge clk) begin
            if (rst_n && vo) begin
                n_checks++;
                if (c !== ACW'(W) || z !== 1'b1 || t !== aux_rx[gi][3:0] || ro !== 1'b1) begin
                    n_fail++;
                    $display("FAIL aux_zero_w%0d: got count=%0d zero=%0b tag=%0d, expected count=%0d zero=1 tag=%0d",
                             W, c, z, t, W, aux_rx[gi][3:0]);
                end
                aux_rx[gi]++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && valid_o) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_result: got count=%0d zero=%0b tag=%0d, expected no result",
                         count_o, is_zero_o, tag_o);
            end else begin
                mon_e = exp_q[0];
                if (count_o !== mon_e.cnt || is_zero_o !== mon_e.z || tag_o !== mon_e.tag) begin
                    n_fail++;
                    $display("FAIL result: got count=%0d zero=%0b tag=%0d, expected count=%0d zero=%0b tag=%0d",
                             count_o, is_zero_o, tag_o, mon_e.cnt, mon_e.z, mon_e.tag);
                end
                if (ready_i) exp_q.pop_front();
            end
        end
    end

    function automatic int ref_count(input logic [DW-1:0] d, input logic md);
        int n = 0;
        if (md) begin
            for (int i = 0; i < DW; i++) begin
                if (d[i]) break;
                n++;
            end
        end else begin
            for (int i = DW - 1; i >= 0; i--) begin
                if (d[i]) break;
                n++;
            end
        end
        return n;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic send(input logic [DW-1:0] op, input logic md, input logic [TW-1:0] tg,
                        input int ecnt, input logic ez);
        bit   done = 0;
        logic rdy;
        exp_t e;
        valid_i   = 1'b1;
        operand_i = op;
        mode_i    = md;
        tag_i     = tg;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            rdy = ready_o;
            @(posedge clk);
            if (rdy) begin
                e.cnt = ecnt[CW-1:0];
                e.z   = ez;
                e.tag = tg;
                exp_q.push_back(e);
                done = 1;
                break;
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got no transfer, expected ready_o within 1000 cycles");
        end
        #1 valid_i = 1'b0;
    endtask

    task automatic send_m(input logic [DW-1:0] op, input logic md, input logic [TW-1:0] tg);
        int n = ref_count(op, md);
        send(op, md, tg, n, n == DW);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        #1 chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; valid_i = 1'b0; operand_i = '0; mode_i = 1'b0; tag_i = '0; ready_i = 1'b1;
        aux_valid = 1'b0; aux_mode = 1'b0; aux_tag = '0; aux_op = '0; aux_ready = 1'b1;
        rnd_stop = 0;
        #2;
        chk("reset_valid_o", 64'(valid_o), 64'd0);
        chk("reset_ready_o", 64'(ready_o), 64'd1);
        chk("reset_count_o", 64'(count_o), 64'd0);
        chk("reset_is_zero", 64'(is_zero_o), 64'd0);
        chk("reset_tag_o", 64'(tag_o), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // All-zero operands in both modes on the 8/16/64-bit instances.
        aux_valid = 1'b1; aux_mode = 1'b0; aux_tag = 4'd0;
        @(posedge clk); #1 aux_mode = 1'b1; aux_tag = 4'd1;
        @(posedge clk); #1 aux_valid = 1'b0;

        // Leading 0x0001_0000 with a two-cycle latency check.
        send(32'h0001_0000, 1'b0, 4'd3, 15, 1'b0);
        @(negedge clk); chk("latency_cycle1_valid", 64'(valid_o), 64'd0);
        @(negedge clk); chk("latency_cycle2_valid", 64'(valid_o), 64'd1);
        drain();

        // Hand-computed directed vectors, mixed modes, back to back.
        send(32'h0001_0000, 1'b1, 4'd4, 16, 1'b0);
        send(32'h8000_0000, 1'b1, 4'd5, 31, 1'b0);
        send(32'h0000_0001, 1'b1, 4'd6, 0,  1'b0);
        send(32'h0000_0000, 1'b0, 4'd7, 32, 1'b1);
        send(32'h0000_0000, 1'b1, 4'd8, 32, 1'b1);
        send(32'h8000_0000, 1'b0, 4'd9, 0,  1'b0);
        send(32'h0000_0001, 1'b0, 4'd10, 31, 1'b0);
        send(32'h0000_0F00, 1'b0, 4'd11, 20, 1'b0);
        send(32'h0000_0F00, 1'b1, 4'd12, 8,  1'b0);
        drain();

        // Ten-operand stream, alternating modes, ready_i low for cycles 3..6.
        fork
            begin
                for (int i = 0; i < 10; i++)
                    send_m(32'h0000_0001 << (3 * i + 1), 1'(i % 2), 4'(i));
            end
            begin
                repeat (2) @(posedge clk);
                #1 ready_i = 1'b0;
                repeat (4) @(posedge clk);
                #1 ready_i = 1'b1;
                #1 chk("ready_rise_same_cycle", 64'(ready_o), 64'd1);
            end
            begin
                repeat (3) @(posedge clk);
                @(negedge clk);
                chk("stall_ready_o", 64'(ready_o), 64'd0);
                chk("stall_valid_o", 64'(valid_o), 64'd1);
            end
        join
        drain();

        // Reset with two operands in flight.
        ready_i = 1'b0;
        send(32'h0000_1000, 1'b0, 4'd1, 19, 1'b0);
        send(32'h0000_1000, 1'b1, 4'd2, 12, 1'b0);
        @(negedge clk); #1 rst_n = 1'b0;
        #1;
        chk("midreset_valid_o", 64'(valid_o), 64'd0);
        chk("midreset_ready_o", 64'(ready_o), 64'd1);
        exp_q.delete();
        @(negedge clk); #1 rst_n = 1'b1;
        ready_i = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        send(32'h0400_0000, 1'b0, 4'd13, 5, 1'b0);
        @(negedge clk); chk("post_reset_cycle1_valid", 64'(valid_o), 64'd0);
        @(negedge clk); chk("post_reset_cycle2_valid", 64'(valid_o), 64'd1);
        drain();

        // Randomised operands and back-pressure against the reference model.
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    logic [DW-1:0] op;
                    op = ($urandom_range(0, 15) == 0) ? '0 : ($urandom >> $urandom_range(0, 31));
                    send_m(op, 1'($urandom_range(0, 1)), 4'(i));
                end
                rnd_stop = 1;
            end
            begin
                while (!rnd_stop) begin
                    @(posedge clk);
                    #1 ready_i = 1'($urandom_range(0, 1));
                end
            end
        join
        ready_i = 1'b1;
        drain();

        for (int g = 0; g < 3; g++) chk("aux_result_count", 64'(aux_rx[g]), 64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
